// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared types and pitch table for the piano tone generator
//
// Purpose : FSM state type and the C4..B4 half-period table at a 25 MHz clock.
// Ports   : none (package).

package piano_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int NUM_BASE = 12;

    // Half-period in clock cycles for key 0 (C4) .. key 11 (B4) at 25 MHz.
    localparam logic [15:0] BASE [0:NUM_BASE-1] = '{
        16'd47777, 16'd45097, 16'd42566, 16'd40176,
        16'd37921, 16'd35793, 16'd33784, 16'd31887,
        16'd30098, 16'd28409, 16'd26814, 16'd25309
    };

    // Table lookup that stays in range for any 4-bit index; indices past the
    // table clamp to the top entry.
    function automatic logic [15:0] base_half_period(input logic [3:0] idx);
        logic [15:0] r;
        r = BASE[NUM_BASE-1];
        for (int i = 0; i < NUM_BASE; i++) begin
            if (idx == i[3:0]) begin
                r = BASE[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - highest-pressed-key priority encoder
//
// Purpose : combinational; reports whether any key is down and the index of
//           the highest set key.
// Ports   : keys [NUM_KEYS] in  - debounced key vector, bit i = key i
//           any            out - at least one key pressed
//           sel  [4]       out - index of highest pressed key (0 when none)

module key_prio_enc
    import piano_pkg::*;
#(
    parameter int NUM_KEYS = 12
) (
    input  logic [NUM_KEYS-1:0] keys,
    output logic                any,
    output logic [3:0]          sel
);

    always_comb begin
        sel = 4'd0;
        // Later iterations override earlier ones, so the highest set bit wins.
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                sel = i[3:0];
            end
        end
        any = |keys;
    end

endmodule

// File: rtl/tone_gen_poly.sv
// rtl/tone_gen_poly.sv - octave-shifted square-wave piano tone generator
//
// Purpose : drives the speaker with a square wave whose half-period is
//           BASE[highest key] >> octave. Pitch changes and stops only at a
//           half-period boundary, so no runt pulses reach the speaker.
// Ports   : clk       in  - system clock
//           reset     in  - synchronous, active-high
//           keys      in  - debounced key vector, bit i = key i
//           octave    in  - octave-up shift applied to the table entry
//           mute      in  - forces speaker low, tone timing keeps running
//           speaker   out - square-wave tone
//           counter   out - position within current half-period
//           note_idx  out - key index currently sounding
//           active    out - high while a tone is playing or draining

module tone_gen_poly
    import piano_pkg::*;
#(
    parameter int NUM_KEYS = 12,
    parameter int CNT_W    = 16,
    parameter int OCT_W    = 3,
    parameter int CLK_HZ   = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [OCT_W-1:0]    octave,
    input  logic                mute,
    output logic                speaker,
    output logic [CNT_W-1:0]    counter,
    output logic [3:0]          note_idx,
    output logic                active
);

    // The pitch table is only meaningful at 25 MHz and needs 16 counter bits.
    if (CNT_W < 16 || CLK_HZ != 25_000_000) begin : g_bad_params
        $error("tone_gen_poly: table requires CLK_HZ=25_000_000 and CNT_W>=16");
    end

    state_t             state, state_n;
    logic [CNT_W-1:0]   period, period_n;
    logic [CNT_W-1:0]   counter_n;
    logic [3:0]         note_n;
    logic               tone, tone_n;

    logic               any;
    logic [3:0]         sel;
    logic [CNT_W-1:0]   pend;
    logic               terminal;

    key_prio_enc #(
        .NUM_KEYS (NUM_KEYS)
    ) u_prio (
        .keys (keys),
        .any  (any),
        .sel  (sel)
    );

    // Candidate half-period, recomputed every cycle but only latched at a
    // boundary (or on the first press from IDLE).
    assign pend     = CNT_W'(base_half_period(sel)) >> octave;
    assign terminal = (counter == period - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            period   <= '0;
            tone     <= 1'b0;
            note_idx <= 4'd0;
        end else begin
            state    <= state_n;
            counter  <= counter_n;
            period   <= period_n;
            tone     <= tone_n;
            note_idx <= note_n;
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        period_n  = period;
        tone_n    = tone;
        note_n    = note_idx;
        case (state)
            IDLE: begin
                counter_n = '0;
                tone_n    = 1'b0;
                if (any) begin
                    state_n  = PLAY;
                    period_n = pend;
                    note_n   = sel;
                    tone_n   = 1'b1;
                end
            end
            PLAY, DRAIN: begin
                if (terminal) begin
                    counter_n = '0;
                    if (!any) begin
                        // Keys up at a boundary ends the note here, whether
                        // the release came earlier (DRAIN) or on this very
                        // cycle (PLAY).
                        tone_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        tone_n   = ~tone;
                        period_n = pend;
                        note_n   = sel;
                        state_n  = PLAY;
                    end
                end else begin
                    counter_n = counter + CNT_W'(1);
                    // A re-press while draining simply resumes; the running
                    // half-period is never restarted.
                    state_n   = any ? PLAY : DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign speaker = tone & ~mute;
    assign active  = (state != IDLE);

endmodule

// File: tb/tb_tone_gen_poly.sv
// tb/tb_tone_gen_poly.sv - scoreboard bench for tone_gen_poly

module tb_tone_gen_poly;

    localparam int NK = 12;
    localparam int CW = 16;
    localparam int OW = 3;

    localparam logic [NK-1:0] K_NONE = 12'h000;
    localparam logic [NK-1:0] K_C4   = 12'h001;
    localparam logic [NK-1:0] K_D4   = 12'h004;
    localparam logic [NK-1:0] K_E4   = 12'h010;
    localparam logic [NK-1:0] K_A4   = 12'h200;
    localparam logic [NK-1:0] K_B4   = 12'h800;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys = '0;
    logic [OW-1:0] octave = '0;
    logic          mute = 1'b0;
    logic          speaker;
    logic [CW-1:0] counter;
    logic [3:0]    note_idx;
    logic          active;

    tone_gen_poly #(
        .NUM_KEYS (NK),
        .CNT_W    (CW),
        .OCT_W    (OW),
        .CLK_HZ   (25_000_000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .keys     (keys),
        .octave   (octave),
        .mute     (mute),
        .speaker  (speaker),
        .counter  (counter),
        .note_idx (note_idx),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic spk;
        int   cnt;
        int   idx;
        logic act;
    } exp_t;

    exp_t exp_q[$];

    int base_tab [12] = '{47777, 45097, 42566, 40176, 37921, 35793,
                          33784, 31887, 30098, 28409, 26814, 25309};

    // Reference model: a note is either sounding or silent. While sounding,
    // the current half-phase has length m_len and we are m_pos cycles into it.
    int m_on  = 0;
    int m_lvl = 0;
    int m_len = 0;
    int m_pos = 0;
    int m_idx = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NK-1:0] k, input int o);
        int sel;
        int pend;
        sel = 0;
        for (int i = 0; i < NK; i++) begin
            if (k[i]) sel = i;
        end
        pend = base_tab[sel] >> o;
        if (r) begin
            m_on = 0; m_lvl = 0; m_pos = 0; m_idx = 0; m_len = 0;
        end else if (m_on == 0) begin
            if (k != 0) begin
                m_on = 1; m_lvl = 1; m_pos = 0; m_len = pend; m_idx = sel;
            end
        end else if (m_pos == m_len - 1) begin
            m_pos = 0;
            if (k == 0) begin
                m_on = 0; m_lvl = 0;
            end else begin
                m_lvl = 1 - m_lvl; m_len = pend; m_idx = sel;
            end
        end else begin
            m_pos++;
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, queue the
    // expected outputs, then move past the falling edge before returning.
    task automatic step(input logic r, input logic [NK-1:0] k, input int o, input logic m);
        exp_t e;
        reset  = r;
        keys   = k;
        octave = OW'(o);
        mute   = m;
        @(posedge clk);
        model_edge(r, k, o);
        e.spk = (m_lvl != 0) && !m;
        e.cnt = m_pos;
        e.idx = m_idx;
        e.act = (m_on != 0);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run_until(input int pos, input int lvl, input logic [NK-1:0] k, input int o);
        bit hit;
        hit = 0;
        for (int i = 0; i < 4000; i++) begin
            if (m_on != 0 && m_pos == pos && (lvl < 0 || m_lvl == lvl)) begin
                hit = 1;
                break;
            end
            step(1'b0, k, o, 1'b0);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL run_until timeout: got no match expected pos %0d", pos);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("speaker",  32'(speaker),  32'(e.spk));
            chk("counter",  32'(counter),  e.cnt);
            chk("note_idx", 32'(note_idx), e.idx);
            chk("active",   32'(active),   32'(e.act));
        end
    end

    initial begin
        logic [NK-1:0] rk;
        int            ro;
        int            rlen;
        logic          rm;

        repeat (3) step(1'b1, K_NONE, 0, 1'b0);

        // A4 at octave 7: 221-cycle half-periods.
        repeat (900) step(1'b0, K_A4, 7, 1'b0);
        // Highest key wins over C4.
        repeat (500) step(1'b0, K_A4 | K_C4, 7, 1'b0);

        // Retune to B4 mid-phase; current phase must finish at 221.
        run_until(50, -1, K_A4, 7);
        repeat (900) step(1'b0, K_B4, 7, 1'b0);

        // Release while high at counter 100 of an A4 phase.
        repeat (250) step(1'b0, K_A4, 7, 1'b0);
        run_until(100, 1, K_A4, 7);
        repeat (400) step(1'b0, K_NONE, 7, 1'b0);

        // Reset held mid-note, then idle.
        repeat (300) step(1'b0, K_E4, 7, 1'b0);
        repeat (5) step(1'b1, K_E4, 7, 1'b0);
        repeat (20) step(1'b0, K_NONE, 7, 1'b0);

        // Mute for 300 cycles during play; counter must stay continuous.
        repeat (100) step(1'b0, K_D4, 7, 1'b0);
        repeat (300) step(1'b0, K_D4, 7, 1'b1);
        repeat (400) step(1'b0, K_D4, 7, 1'b0);

        // Release and re-press inside one half-period is seamless.
        run_until(10, -1, K_D4, 7);
        repeat (20) step(1'b0, K_NONE, 7, 1'b0);
        repeat (400) step(1'b0, K_D4, 7, 1'b0);

        // Release on exactly the terminal-count cycle.
        run_until(331, -1, K_D4, 7);
        repeat (50) step(1'b0, K_NONE, 7, 1'b0);

        // Press from IDLE: one-cycle latency.
        repeat (30) step(1'b0, K_C4, 7, 1'b0);
        repeat (400) step(1'b0, K_NONE, 7, 1'b0);

        // Randomized segments.
        for (int s = 0; s < 40; s++) begin
            rk   = NK'($urandom());
            if ($urandom_range(0, 3) == 0) rk = K_NONE;
            ro   = $urandom_range(5, 7);
            rm   = ($urandom_range(0, 9) == 0);
            rlen = $urandom_range(1, 700);
            if ($urandom_range(0, 29) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b1, rk, ro, rm);
            end
            repeat (rlen) step(1'b0, rk, ro, rm);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
